shift_scroll_ctrl: RTL and testbench

//  Sequencer for the two-digit circular-shift display datapath. Latches a 3-digit BCD

---
 rtl/shift_scroll_ctrl_if.sv | 30 +++
 rtl/shift_scroll_ctrl.sv | 160 ++++++++++++++++
 tb/tb_shift_scroll_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_scroll_ctrl_if.sv
// rtl/shift_scroll_ctrl_if.sv - result/display bus between measurement FSM, sequencer and shifter
interface shift_scroll_ctrl_if;
  logic       result_valid;
  logic [3:0] result_digit_2;
  logic [3:0] result_digit_1;
  logic [3:0] result_digit_0;
  logic       clear;
  logic       shift_enable;
  logic [3:0] hold_digit_2;
  logic [3:0] hold_digit_1;
  logic [3:0] hold_digit_0;
  logic       disp_sel;
  logic       blank;
  logic [1:0] step_pos;
  logic       bcd_err;

  // Measurement-FSM side: supplies results and clear, observes display state
  modport master (
    output result_valid, result_digit_2, result_digit_1, result_digit_0, clear,
    input  shift_enable, hold_digit_2, hold_digit_1, hold_digit_0,
           disp_sel, blank, step_pos, bcd_err
  );

  // Sequencer side
  modport slave (
    input  result_valid, result_digit_2, result_digit_1, result_digit_0, clear,
    output shift_enable, hold_digit_2, hold_digit_1, hold_digit_0,
           disp_sel, blank, step_pos, bcd_err
  );
endinterface

// File: rtl/shift_scroll_ctrl.sv
// rtl/shift_scroll_ctrl.sv - reaction-time display sequencer (static / scrolling / blank)
module shift_scroll_ctrl #(
  parameter int TICK_DIV     = 10_000_000,
  parameter int STATIC_TICKS = 30,
  parameter int SCROLL_LOOPS = 3
) (
  input  logic               clk,
  input  logic               rstn,
  shift_scroll_ctrl_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int TW = (STATIC_TICKS > 1) ? $clog2(STATIC_TICKS) : 1;
  localparam int LW = $clog2(SCROLL_LOOPS + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [TW-1:0] TICK_LAST = TW'(STATIC_TICKS - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [LW-1:0] LOOP_LAST = LW'(SCROLL_LOOPS);
  localparam logic [LW-1:0] LOOP_ONE  = LW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STATIC = 2'd1,
    S_SCROLL = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [PW-1:0] r_presc,    w_presc_nxt;
  logic [TW-1:0] r_tick_cnt, w_tick_cnt_nxt;
  logic [LW-1:0] r_loop_cnt, w_loop_nxt;
  logic [1:0]    r_step_pos, w_step_nxt;
  logic          r_shift_en, w_shift_en_nxt;
  logic [3:0]    r_hold_2,   w_hold_2_nxt;
  logic [3:0]    r_hold_1,   w_hold_1_nxt;
  logic [3:0]    r_hold_0,   w_hold_0_nxt;
  logic          r_disp_sel, w_disp_sel_nxt;
  logic          r_blank,    w_blank_nxt;
  logic          r_bcd_err,  w_bcd_err_nxt;

  logic w_digits_ok;
  logic w_accept;
  logic w_reject;
  logic w_tick;
  logic w_static_done;
  logic w_scroll_done;

  // clear masks the result entirely, so a simultaneous bad digit raises no error
  assign w_digits_ok   = (bus.result_digit_2 <= 4'd9) && (bus.result_digit_1 <= 4'd9) &&
                         (bus.result_digit_0 <= 4'd9);
  assign w_accept      = bus.result_valid && !bus.clear && w_digits_ok;
  assign w_reject      = bus.result_valid && !bus.clear && !w_digits_ok;
  assign w_tick        = (r_state != S_IDLE) && (r_presc == PRESC_MAX);
  assign w_static_done = (r_state == S_STATIC) && w_tick && (r_tick_cnt == TICK_LAST);
  // Finish one cycle after the pulse that completed the last rotation
  assign w_scroll_done = (r_state == S_SCROLL) && r_shift_en && (r_loop_cnt == LOOP_LAST);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: clear beats a new result, a new result beats normal sequencing
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = S_IDLE;
    end else if (w_accept) begin
      w_state_nxt = (bus.result_digit_2 == 4'd0) ? S_STATIC : S_SCROLL;
    end else begin
      case (r_state)
        S_STATIC: if (w_static_done) w_state_nxt = S_IDLE;
        S_SCROLL: if (w_scroll_done) w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output/datapath next values; every output is taken from a register below
  always_comb begin
    w_hold_2_nxt   = r_hold_2;
    w_hold_1_nxt   = r_hold_1;
    w_hold_0_nxt   = r_hold_0;
    w_presc_nxt    = (r_state == S_IDLE || w_tick) ? '0 : r_presc + PRESC_ONE;
    w_tick_cnt_nxt = r_tick_cnt;
    w_loop_nxt     = r_loop_cnt;
    w_step_nxt     = r_step_pos;
    w_shift_en_nxt = 1'b0;
    w_bcd_err_nxt  = w_reject;
    if (w_state_nxt == S_IDLE) begin
      w_presc_nxt    = '0;
      w_tick_cnt_nxt = '0;
      w_loop_nxt     = '0;
      w_step_nxt     = 2'd0;
    end else if (w_accept) begin
      w_hold_2_nxt   = bus.result_digit_2;
      w_hold_1_nxt   = bus.result_digit_1;
      w_hold_0_nxt   = bus.result_digit_0;
      w_presc_nxt    = '0;
      w_tick_cnt_nxt = '0;
      w_loop_nxt     = '0;
      w_step_nxt     = 2'd0;
    end else if (r_state == S_SCROLL && w_tick) begin
      w_shift_en_nxt = 1'b1;
      if (r_step_pos == 2'd2) begin
        w_step_nxt = 2'd0;
        w_loop_nxt = r_loop_cnt + LOOP_ONE;
      end else begin
        w_step_nxt = r_step_pos + 2'd1;
      end
    end else if (r_state == S_STATIC && w_tick) begin
      w_tick_cnt_nxt = r_tick_cnt + TICK_ONE;
    end
    w_blank_nxt    = (w_state_nxt == S_IDLE);
    w_disp_sel_nxt = (w_state_nxt == S_SCROLL);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_presc    <= '0;
      r_tick_cnt <= '0;
      r_loop_cnt <= '0;
      r_step_pos <= 2'd0;
      r_shift_en <= 1'b0;
      r_hold_2   <= 4'd0;
      r_hold_1   <= 4'd0;
      r_hold_0   <= 4'd0;
      r_disp_sel <= 1'b0;
      r_blank    <= 1'b1;
      r_bcd_err  <= 1'b0;
    end else begin
      r_presc    <= w_presc_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_loop_cnt <= w_loop_nxt;
      r_step_pos <= w_step_nxt;
      r_shift_en <= w_shift_en_nxt;
      r_hold_2   <= w_hold_2_nxt;
      r_hold_1   <= w_hold_1_nxt;
      r_hold_0   <= w_hold_0_nxt;
      r_disp_sel <= w_disp_sel_nxt;
      r_blank    <= w_blank_nxt;
      r_bcd_err  <= w_bcd_err_nxt;
    end
  end

  assign bus.shift_enable = r_shift_en;
  assign bus.hold_digit_2 = r_hold_2;
  assign bus.hold_digit_1 = r_hold_1;
  assign bus.hold_digit_0 = r_hold_0;
  assign bus.disp_sel     = r_disp_sel;
  assign bus.blank        = r_blank;
  assign bus.step_pos     = r_step_pos;
  assign bus.bcd_err      = r_bcd_err;

endmodule

// File: tb/tb_shift_scroll_ctrl.sv
// tb/tb_shift_scroll_ctrl.sv - scoreboard bench for shift_scroll_ctrl
module tb_shift_scroll_ctrl;
  localparam int TICK_DIV     = 4;
  localparam int STATIC_TICKS = 3;
  localparam int SCROLL_LOOPS = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    int          cyc;
    logic [11:0] hold;
    logic [1:0]  step;
    logic        disp;
  } ev_t;

  ev_t q_load[$];
  ev_t q_shift[$];
  ev_t q_off[$];
  int  q_err[$];

  shift_scroll_ctrl_if bus();

  shift_scroll_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .STATIC_TICKS(STATIC_TICKS),
    .SCROLL_LOOPS(SCROLL_LOOPS)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] hold_now;
  assign hold_now = {bus.hold_digit_2, bus.hold_digit_1, bus.hold_digit_0};

  function automatic ev_t mk(input int c, input logic [11:0] h, input logic [1:0] s, input logic d);
    ev_t e;
    e.cyc = c; e.hold = h; e.step = s; e.disp = d;
    return e;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  // Drive one cycle of result_valid/clear in cycle 'target'
  task automatic issue_at(input int target, input logic [3:0] d2, input logic [3:0] d1,
                          input logic [3:0] d0, input logic clr, input logic vld);
    wait_cyc(target - 1);
    @(posedge clk); #1;
    bus.result_valid   = vld;
    bus.clear          = clr;
    bus.result_digit_2 = d2;
    bus.result_digit_1 = d1;
    bus.result_digit_0 = d0;
    @(posedge clk); #1;
    bus.result_valid = 1'b0;
    bus.clear        = 1'b0;
  endtask

  // Monitor: pop and compare whenever the DUT presents an event
  logic        prev_blank = 1'b1;
  logic        prev_se    = 1'b0;
  logic [11:0] prev_hold  = 12'h000;

  always @(negedge clk) begin
    ev_t e;
    int  ec;
    if (mon_en) begin
      if (bus.shift_enable) begin
        checks++;
        if (q_shift.size() == 0) begin
          errors++;
          $display("FAIL shift_unexpected: pulse at cycle %0d step=%0d, none expected", cyc, bus.step_pos);
        end else begin
          e = q_shift.pop_front();
          if (cyc != e.cyc || bus.step_pos != e.step || hold_now != e.hold || !bus.disp_sel || prev_se) begin
            errors++;
            $display("FAIL shift: got cyc=%0d step=%0d hold=%h disp=%0b back2back=%0b, expected cyc=%0d step=%0d hold=%h disp=1 back2back=0",
                     cyc, bus.step_pos, hold_now, bus.disp_sel, prev_se, e.cyc, e.step, e.hold);
          end
        end
      end
      if (bus.bcd_err) begin
        checks++;
        if (q_err.size() == 0) begin
          errors++;
          $display("FAIL bcd_err_unexpected: pulse at cycle %0d, none expected", cyc);
        end else begin
          ec = q_err.pop_front();
          if (cyc != ec) begin
            errors++;
            $display("FAIL bcd_err: got cycle %0d, expected cycle %0d", cyc, ec);
          end
        end
      end
      if (!bus.blank && (prev_blank || hold_now != prev_hold)) begin
        checks++;
        if (q_load.size() == 0) begin
          errors++;
          $display("FAIL load_unexpected: display loaded at cycle %0d hold=%h", cyc, hold_now);
        end else begin
          e = q_load.pop_front();
          if (cyc != e.cyc || hold_now != e.hold || bus.disp_sel != e.disp || bus.step_pos != 2'd0) begin
            errors++;
            $display("FAIL load: got cyc=%0d hold=%h disp=%0b step=%0d, expected cyc=%0d hold=%h disp=%0b step=0",
                     cyc, hold_now, bus.disp_sel, bus.step_pos, e.cyc, e.hold, e.disp);
          end
        end
      end
      if (bus.blank && !prev_blank) begin
        checks++;
        if (q_off.size() == 0) begin
          errors++;
          $display("FAIL blank_unexpected: blanked at cycle %0d", cyc);
        end else begin
          e = q_off.pop_front();
          if (cyc != e.cyc || hold_now != e.hold || bus.disp_sel || bus.shift_enable || bus.step_pos != 2'd0) begin
            errors++;
            $display("FAIL blank: got cyc=%0d hold=%h disp=%0b se=%0b step=%0d, expected cyc=%0d hold=%h disp=0 se=0 step=0",
                     cyc, hold_now, bus.disp_sel, bus.shift_enable, bus.step_pos, e.cyc, e.hold);
          end
        end
      end
    end
    prev_blank = bus.blank;
    prev_se    = bus.shift_enable;
    prev_hold  = hold_now;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    bus.result_valid   = 1'b0;
    bus.clear          = 1'b0;
    bus.result_digit_2 = 4'd0;
    bus.result_digit_1 = 4'd0;
    bus.result_digit_0 = 4'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_blank", bus.blank, 1);
    chk("rst_shift_enable", bus.shift_enable, 0);
    chk("rst_disp_sel", bus.disp_sel, 0);
    chk("rst_hold", hold_now, 0);
    chk("rst_step_pos", bus.step_pos, 0);
    chk("rst_bcd_err", bus.bcd_err, 0);
    @(negedge clk);
    rstn   = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Static result 0,4,7
    n = cyc + 2;
    q_load.push_back(mk(n + 1, 12'h047, 2'd0, 1'b0));
    q_off.push_back(mk(n + 13, 12'h047, 2'd0, 1'b0));
    issue_at(n, 4'd0, 4'd4, 4'd7, 1'b0, 1'b1);
    wait_cyc(n + 20);

    // Scroll result 9,5,2
    n = cyc + 2;
    q_load.push_back(mk(n + 1, 12'h952, 2'd0, 1'b1));
    for (int k = 0; k < 6; k++)
      q_shift.push_back(mk(n + 5 + 4 * k, 12'h952, 2'((k + 1) % 3), 1'b1));
    q_off.push_back(mk(n + 26, 12'h952, 2'd0, 1'b0));
    issue_at(n, 4'd9, 4'd5, 4'd2, 1'b0, 1'b1);
    wait_cyc(n + 32);

    // Restart: 9,5,2 then 1,2,3 two cycles after the first pulse
    n = cyc + 2;
    m = n + 7;
    q_load.push_back(mk(n + 1, 12'h952, 2'd0, 1'b1));
    q_shift.push_back(mk(n + 5, 12'h952, 2'd1, 1'b1));
    q_load.push_back(mk(m + 1, 12'h123, 2'd0, 1'b1));
    for (int k = 0; k < 6; k++)
      q_shift.push_back(mk(m + 5 + 4 * k, 12'h123, 2'((k + 1) % 3), 1'b1));
    q_off.push_back(mk(m + 26, 12'h123, 2'd0, 1'b0));
    issue_at(n, 4'd9, 4'd5, 4'd2, 1'b0, 1'b1);
    issue_at(m, 4'd1, 4'd2, 4'd3, 1'b0, 1'b1);
    wait_cyc(m + 32);

    // Bad BCD 1,A,3 during static 0,4,7
    n = cyc + 2;
    q_load.push_back(mk(n + 1, 12'h047, 2'd0, 1'b0));
    q_err.push_back(n + 4);
    q_off.push_back(mk(n + 13, 12'h047, 2'd0, 1'b0));
    issue_at(n, 4'd0, 4'd4, 4'd7, 1'b0, 1'b1);
    issue_at(n + 3, 4'd1, 4'hA, 4'd3, 1'b0, 1'b1);
    wait_cyc(n + 20);

    // Bad BCD in IDLE: error pulse only
    n = cyc + 2;
    q_err.push_back(n + 1);
    issue_at(n, 4'hF, 4'd0, 4'd0, 1'b0, 1'b1);
    wait_cyc(n + 6);

    // Clear aborts a scroll after its first pulse
    n = cyc + 2;
    q_load.push_back(mk(n + 1, 12'h952, 2'd0, 1'b1));
    q_shift.push_back(mk(n + 5, 12'h952, 2'd1, 1'b1));
    q_off.push_back(mk(n + 7, 12'h952, 2'd0, 1'b0));
    issue_at(n, 4'd9, 4'd5, 4'd2, 1'b0, 1'b1);
    issue_at(n + 6, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    wait_cyc(n + 15);

    // Clear with simultaneous result in IDLE: result dropped
    n = cyc + 2;
    issue_at(n, 4'd9, 4'd5, 4'd2, 1'b1, 1'b1);
    chk("clear_idle_blank", bus.blank, 1);
    chk("clear_idle_bcd_err", bus.bcd_err, 0);
    wait_cyc(n + 10);
    chk("clear_idle_blank_later", bus.blank, 1);
    chk("clear_idle_disp_sel", bus.disp_sel, 0);

    // Async reset mid-scroll, during a shift pulse
    n = cyc + 2;
    q_load.push_back(mk(n + 1, 12'h952, 2'd0, 1'b1));
    issue_at(n, 4'd9, 4'd5, 4'd2, 1'b0, 1'b1);
    wait_cyc(n + 5);
    chk("pre_reset_pulse", bus.shift_enable, 1);
    mon_en = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    chk("async_rst_blank", bus.blank, 1);
    chk("async_rst_shift_enable", bus.shift_enable, 0);
    chk("async_rst_hold", hold_now, 0);
    chk("async_rst_disp_sel", bus.disp_sel, 0);
    chk("async_rst_step_pos", bus.step_pos, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_blank", bus.blank, 1);
    chk("post_rst_shift_enable", bus.shift_enable, 0);

    // Everything the scoreboard expected must have been seen
    chk("pending_load", q_load.size(), 0);
    chk("pending_shift", q_shift.size(), 0);
    chk("pending_blank", q_off.size(), 0);
    chk("pending_bcd_err", q_err.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
